// File: rtl/dpram_32x1024_sclk.sv
// Simple dual-port RAM (write port A, registered read port B) holding the digital-output waveform table.
// Define DPRAM_WR_BYPASS_EN for write-first collisions; the default build is read-first.
module dpram_32x1024_sclk #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              enb,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    // Table storage; deliberately has no reset so contents survive reset_n.
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en;
    assign wr_en = reset_n && ena && wea;

    // A whole word is written on the edge or not at all.
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem[addra] <= dina;
        end
    end

`ifdef DPRAM_WR_BYPASS_EN
    logic collide;
    assign collide = wr_en && (addra == addrb);

    // Write-first: a same-address write is forwarded straight to doutb.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            doutb <= '0;
        end else if (enb) begin
            if (collide) begin
                doutb <= dina;
            end else begin
                doutb <= mem[addrb];
            end
        end
    end
`else
    // Read-first: the old word is returned on a same-address collision.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            doutb <= '0;
        end else if (enb) begin
            doutb <= mem[addrb];
        end
    end
`endif

endmodule

// File: tb/tb_dpram_32x1024_sclk.sv
// Scoreboard bench for dpram_32x1024_sclk: an array model pushes expected read data, a monitor pops and checks.
module tb_dpram_32x1024_sclk;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;

    logic              sysclk;
    logic              reset_n;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;

    dpram_32x1024_sclk #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .sysclk (sysclk),
        .reset_n(reset_n),
        .ena    (ena),
        .wea    (wea),
        .addra  (addra),
        .dina   (dina),
        .enb    (enb),
        .addrb  (addrb),
        .doutb  (doutb)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] cur_exp;
    logic              mon_rd;
    logic              mon_rst;

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: words as a plain array, read result decided before the write lands.
    always @(posedge sysclk) begin
        if (reset_n) begin
            if (enb) begin
`ifdef DPRAM_WR_BYPASS_EN
                if (ena && wea && addra == addrb) exp_q.push_back(dina);
                else exp_q.push_back(model[addrb]);
`else
                exp_q.push_back(model[addrb]);
`endif
            end
            if (ena && wea) model[addra] = dina;
        end
    end

    // Monitor: every cycle doutb is either a new read result, a held value, or zero in reset.
    initial cur_exp = '0;
    always @(posedge sysclk) begin
        mon_rd  = reset_n && enb;
        mon_rst = !reset_n;
        #1;
        if (mon_rst) begin
            cur_exp = '0;
        end else if (mon_rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got doutb %h want a queued entry at %0t", doutb, $time);
            end else begin
                cur_exp = exp_q.pop_front();
            end
        end
        chk("monitor_doutb", doutb, cur_exp);
    end

    // One clock cycle of port activity; returns 1 time unit after the edge.
    task automatic cyc(input logic ea, input logic wa, input logic [ADDR_W-1:0] aa,
                       input logic [DATA_W-1:0] da, input logic eb, input logic [ADDR_W-1:0] ab);
        @(negedge sysclk);
        ena = ea; wea = wa; addra = aa; dina = da; enb = eb; addrb = ab;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        reset_n = 1'b0;
        ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        enb = 1'b1; addrb = 10'd5;

        // Reset held with a read pending
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5);
        chk("reset_hold", doutb, 32'h0);
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd5);
        @(negedge sysclk);
        reset_n = 1'b1;
        @(posedge sysclk);
        #1;
        chk("post_reset_read5", doutb, 32'h0);

        // Write then read at both address extremes
        cyc(1'b1, 1'b1, 10'h000, 32'h80000103, 1'b0, 10'd0);
        cyc(1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF, 1'b0, 10'd0);
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'h000);
        chk("read_addr0", doutb, 32'h80000103);
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'h3FF);
        chk("read_addr3ff", doutb, 32'hDEADBEEF);

        // Write-enable gating
        cyc(1'b1, 1'b1, 10'd7, 32'h12345678, 1'b0, 10'd0);
        cyc(1'b1, 1'b0, 10'd7, 32'hFFFFFFFF, 1'b0, 10'd0);
        cyc(1'b0, 1'b1, 10'd7, 32'h00000000, 1'b0, 10'd0);
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd7);
        chk("we_gating", doutb, 32'h12345678);

        // Read-enable hold
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'h000);
        chk("hold_pre", doutb, 32'h80000103);
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'h3FF);
        chk("hold_enb0", doutb, 32'h80000103);

        // Same-address collision
        cyc(1'b1, 1'b1, 10'd9, 32'h11111111, 1'b0, 10'd0);
        cyc(1'b1, 1'b1, 10'd9, 32'h22222222, 1'b1, 10'd9);
`ifdef DPRAM_WR_BYPASS_EN
        chk("collision_write_first", doutb, 32'h22222222);
`else
        chk("collision_read_first", doutb, 32'h11111111);
`endif
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd9);
        chk("collision_next_read", doutb, 32'h22222222);

        // Mid-operation asynchronous reset; contents must survive, writes in reset are dropped
        cyc(1'b1, 1'b1, 10'd3, 32'hA5A5_0003, 1'b0, 10'd0);
        for (int a = 0; a < 4; a++) cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, ADDR_W'(a));
        chk("stream_addr3", doutb, 32'hA5A5_0003);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_now", doutb, 32'h0);
        cyc(1'b1, 1'b1, 10'd3, 32'hBAD0_BAD0, 1'b1, 10'd3);
        chk("reset_write_blocked_dout", doutb, 32'h0);
        @(negedge sysclk);
        ena = 1'b0; wea = 1'b0;
        reset_n = 1'b1;
        @(posedge sysclk);
        #1;
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 10'd3);
        chk("survive_reset_addr3", doutb, 32'hA5A5_0003);

        // Randomized traffic, narrow address range to provoke collisions and rewrites
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] ra;
            logic [ADDR_W-1:0] rb;
            if (n % 3 == 0) begin
                ra = ADDR_W'($urandom);
                rb = ADDR_W'($urandom);
            end else begin
                ra = ADDR_W'($urandom_range(0, 7));
                rb = ADDR_W'($urandom_range(0, 7));
            end
            cyc(1'($urandom), 1'($urandom), ra, DATA_W'($urandom), 1'($urandom), rb);
        end

        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
        cyc(1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 10'd0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
